// File: rtl/palindrome_gen.sv
// Builds the 5-digit decimal palindrome "abcba" from a 3-digit seed "abc".
// Digits are extracted by repeated subtraction, so no divider is needed.
module palindrome_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  seed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] palindrome,
  output logic        range_err
);

  typedef enum logic [2:0] {IDLE, HUND, TENS, BUILD, DONE} state_t;

  state_t     state;
  logic [9:0] rem;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;

  // Weighted sum a*10001 + b*1010 + c*100 held at 17 bits before truncation.
  function automatic logic [16:0] pal_sum(input logic [3:0] a_d,
                                          input logic [3:0] b_d,
                                          input logic [3:0] c_d);
    pal_sum = 17'(a_d) * 17'd10001 + 17'(b_d) * 17'd1010 + 17'(c_d) * 17'd100;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      range_err  <= 1'b0;
      palindrome <= 16'd0;
      rem        <= 10'd0;
      a          <= 4'd0;
      b          <= 4'd0;
      c          <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem      <= seed;
            a        <= 4'd0;
            b        <= 4'd0;
            in_ready <= 1'b0;
            // Seeds of 655 and above would produce a value beyond 16 bits.
            if (seed >= 10'd655) begin
              state      <= DONE;
              range_err  <= 1'b1;
              palindrome <= 16'd0;
              out_valid  <= 1'b1;
            end else begin
              state <= HUND;
            end
          end
        end
        HUND: begin
          if (rem >= 10'd100) begin
            rem <= rem - 10'd100;
            a   <= a + 4'd1;
          end else begin
            state <= TENS;
          end
        end
        TENS: begin
          if (rem >= 10'd10) begin
            rem <= rem - 10'd10;
            b   <= b + 4'd1;
          end else begin
            c     <= rem[3:0];
            state <= BUILD;
          end
        end
        BUILD: begin
          palindrome <= 16'(pal_sum(a, b, c));
          range_err  <= 1'b0;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palindrome_gen.sv
// Directed and randomized bench for palindrome_gen against a digit-level
// reference model of the "abcba" construction.
module tb_palindrome_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  seed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] palindrome;
  logic        range_err;

  int checks = 0;
  int errors = 0;

  palindrome_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .seed       (seed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .palindrome (palindrome),
    .range_err  (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: spell out the digits a,b,c,b,a and read them back as decimal.
  function automatic int ref_pal(input int s);
    int d[5];
    int v;
    if (s > 654) return 0;
    d[0] = s / 100;
    d[1] = (s / 10) % 10;
    d[2] = s % 10;
    d[3] = d[1];
    d[4] = d[0];
    v = 0;
    for (int i = 0; i < 5; i++) v = v * 10 + d[i];
    return v;
  endfunction

  function automatic int ref_lat(input int s);
    if (s > 654) return 0;
    return s / 100 + (s / 10) % 10 + 3;
  endfunction

  function automatic logic is_pal5(input int v);
    int d[5];
    for (int i = 0; i < 5; i++) begin
      d[i] = v % 10;
      v = v / 10;
    end
    return (d[0] == d[4]) && (d[1] == d[3]);
  endfunction

  // Offer one seed, wait for the result, check it, then hold it for
  // hold_cycles with out_ready low before consuming it.
  task automatic run(input int s, input int hold_cycles, input bit keep_ready);
    int n;
    string t;
    t = $sformatf("seed%0d", s);
    out_ready = keep_ready;
    in_valid  = 1'b1;
    seed      = 10'(s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seed     = 10'($urandom_range(0, 1023));
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      check({t, "_busy_in_ready"}, 32'(in_ready), 0);
      @(posedge clk); #1;
      n++;
    end
    check({t, "_out_valid"}, 32'(out_valid), 1);
    check({t, "_latency"}, 32'(n), 32'(ref_lat(s)));
    check({t, "_palindrome"}, 32'(palindrome), 32'(ref_pal(s)));
    check({t, "_range_err"}, 32'(range_err), (s > 654) ? 1 : 0);
    check({t, "_digit_check"}, 32'(is_pal5(int'(palindrome))), 1);
    if (!keep_ready) begin
      for (int i = 0; i < hold_cycles; i++) begin
        in_valid = 1'b1;
        seed     = 10'd50;
        @(posedge clk); #1;
        check({t, "_hold_valid"}, 32'(out_valid), 1);
        check({t, "_hold_pal"}, 32'(palindrome), 32'(ref_pal(s)));
        check({t, "_hold_in_ready"}, 32'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({t, "_drop_valid"}, 32'(out_valid), 0);
    check({t, "_idle_in_ready"}, 32'(in_ready), 1);
    out_ready = keep_ready;
  endtask

  initial begin
    int pulses;
    // Reset with a seed offered on the reset edges; it must not be taken.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    seed      = 10'd5;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_palindrome", 32'(palindrome), 0);
    check("rst_range_err", 32'(range_err), 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 1);
    check("post_rst_out_valid", 32'(out_valid), 0);

    // Directed values from the requirement examples.
    run(123, 0, 1'b0);
    run(654, 0, 1'b0);
    run(655, 0, 1'b0);
    run(0, 0, 1'b0);
    run(9, 0, 1'b0);
    run(100, 0, 1'b0);

    // Backpressure: result held for five cycles while a new seed is offered.
    run(321, 5, 1'b0);
    @(posedge clk); #1;
    check("bp_ignored_seed_valid", 32'(out_valid), 0);
    check("bp_ignored_seed_ready", 32'(in_ready), 1);

    // Reset during HUND discards the pending result.
    in_valid = 1'b1;
    seed     = 10'd555;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_palindrome", 32'(palindrome), 0);
    check("midrst_range_err", 32'(range_err), 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    run(12, 0, 1'b0);

    // Random seeds, including out-of-range ones, with random hold times.
    for (int i = 0; i < 30; i++) begin
      run(int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Full sweep with the consumer always ready.
    for (int s = 0; s <= 654; s++) begin
      run(s, 0, 1'b1);
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/palindrome_gen.md
PALINDROME_GEN -- requirements
Module: palindrome_gen

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  seed offered this cycle.
REQ-005 in_ready  output  1  block can accept a seed (high only in IDLE).
REQ-006 seed  input  10  3-digit decimal prefix "abc", legal range 0..654.
REQ-007 out_valid  output  1  result present on palindrome/range_err.
REQ-008 out_ready  input  1  consumer accepts the result this cycle.
REQ-009 palindrome  output  16  unsigned binary value of the 5-digit decimal "abcba".
REQ-010 range_err  output  1  seed was out of range; palindrome forced to 0.

Function
REQ-011 States SHALL be IDLE, HUND, TENS, BUILD and DONE, held in a registered FSM.
REQ-012 An accept SHALL occur on an edge where in_valid=1 and in_ready=1 (edge E0). Seed is captured into remainder register rem, and digit counters a and b are cleared.
REQ-013 At E0 with seed<=654, the next state SHALL be HUND. With seed>=655 (abcba would exceed 65535), the next state SHALL be DONE with range_err=1, palindrome=0 and out_valid=1 after E0.
REQ-014 HUND, per edge: if rem>=100, then rem-=100 and a+=1, staying in HUND; otherwise go to TENS with rem unchanged. HUND lasts exactly a+1 edges.
REQ-015 TENS, per edge: if rem>=10, then rem-=10 and b+=1, staying in TENS; otherwise go to BUILD with c=rem. TENS lasts exactly b+1 edges.
REQ-016 BUILD, one edge: palindrome <= a*10001 + b*1010 + c*100, computed with 17-bit intermediates and truncated to 16 bits. Also range_err<=0, out_valid<=1, state<=DONE.
REQ-017 No divider SHALL be used; digit extraction is by repeated subtraction only.
REQ-018 Latency: out_valid SHALL rise after edge E(a+b+3) for in-range seeds, and after E0 for out-of-range seeds.
REQ-019 DONE: palindrome, range_err and out_valid SHALL hold stable until an edge with out_ready=1. On that edge out_valid<=0 and state<=IDLE, so in_ready=1 on the following cycle.
REQ-020 in_valid SHALL be ignored in every state except IDLE. A changing seed outside IDLE SHALL not affect the result in progress.
REQ-021 Seeds below 100 SHALL be treated as zero-padded, e.g. seed 7 yields decimal 00700 (= 700). Every legal output satisfies the team's 5-digit palindrome check (d0==d4, d1==d3).
REQ-022 There SHALL be no overlap: in_ready=0 throughout HUND, TENS, BUILD and DONE, and there is no input buffering.

Reset
REQ-023 On an edge with rst_n=0: state<=IDLE, out_valid<=0, range_err<=0, palindrome<=0, rem/a/b/c<=0, and in_ready=1 on the cycle after reset deasserts.
REQ-024 Reset mid-computation or in DONE SHALL discard the pending result; no out_valid pulse SHALL follow.
REQ-025 in_valid asserted on a reset edge SHALL not be accepted.

Verification
REQ-026 seed=123 accepted at E0 -> out_valid high after E6, palindrome=12321, range_err=0.
REQ-027 seed=654 -> out_valid after E14, palindrome=65456; seed=655 -> out_valid after E0, range_err=1, palindrome=0.
REQ-028 seed=0 -> out_valid after E3, palindrome=0. seed=9 -> palindrome=900. seed=100 -> palindrome=10001 after E4.
REQ-029 Backpressure: seed=321, out_ready low for 5 cycles after out_valid -> outputs hold 32123, in_ready=0, and a new seed offered is ignored. out_ready=1 -> out_valid drops and in_ready=1 on the next cycle.
REQ-030 Reset mid-operation: seed=555, rst_n=0 during HUND -> all outputs 0, no out_valid. A next seed=12 -> palindrome=1210 after E4.
REQ-031 Sweep all seeds 0..654 back-to-back with out_ready=1 -> each result equals the decimal abcba, passes the 5-digit palindrome check, and meets the latency in REQ-018.
